// File: rtl/modbus_req_ctrl.sv
// Modbus RTU slave request sequencer: latches a received frame, waits for the CRC verdict,
// decodes function 0x03/0x06, drives the register file and streams the response words out.
module modbus_req_ctrl #(
    parameter logic [15:0] REG_NUM = 16'd16,
    parameter logic [15:0] MAX_RD  = 16'd16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rx_message_done,
    input  logic [7:0]  func_code,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    input  logic [15:0] crc_rx_code,
    output logic        crc_start,
    input  logic        crc_done,
    input  logic [15:0] crc_calc,
    output logic        reg_rd_en,
    output logic        reg_wr_en,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic        tx_start,
    output logic [7:0]  tx_func,
    output logic [7:0]  tx_exc,
    output logic [7:0]  tx_len,
    output logic [15:0] tx_word,
    output logic        tx_word_valid,
    input  logic        tx_word_ready,
    input  logic        tx_done,
    output logic        busy,
    output logic [7:0]  crc_err_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CRC_WAIT,
        S_DECODE,
        S_RD_REQ,
        S_RD_DATA,
        S_RD_PUSH,
        S_WR,
        S_WR_HDR,
        S_WR_PUSH,
        S_WAIT_TX
    } state_t;

    state_t      state;
    logic [7:0]  lat_func;
    logic [15:0] lat_addr;
    logic [15:0] lat_data;
    logic [15:0] lat_crc;
    logic [15:0] word_idx;
    logic [15:0] idx_next;
    logic [7:0]  dec_exc;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Range check is done on 17 bits so addr+count cannot wrap past the map.
    function automatic logic [7:0] rd_exc(input logic [15:0] a, input logic [15:0] c);
        if (c == 16'd0 || c > MAX_RD)
            return 8'h03;
        else if (({1'b0, a} + {1'b0, c}) > {1'b0, REG_NUM})
            return 8'h02;
        else
            return 8'h00;
    endfunction

    always_comb begin
        dec_exc = 8'h00;
        case (lat_func)
            8'h03:   dec_exc = rd_exc(lat_addr, lat_data);
            8'h06:   dec_exc = (lat_addr >= REG_NUM) ? 8'h02 : 8'h00;
            default: dec_exc = 8'h01;
        endcase
    end

    assign idx_next = word_idx + 16'd1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= S_IDLE;
            lat_func      <= 8'h00;
            lat_addr      <= 16'h0000;
            lat_data      <= 16'h0000;
            lat_crc       <= 16'h0000;
            word_idx      <= 16'h0000;
            crc_start     <= 1'b0;
            reg_rd_en     <= 1'b0;
            reg_wr_en     <= 1'b0;
            reg_addr      <= 16'h0000;
            reg_wdata     <= 16'h0000;
            tx_start      <= 1'b0;
            tx_func       <= 8'h00;
            tx_exc        <= 8'h00;
            tx_len        <= 8'h00;
            tx_word       <= 16'h0000;
            tx_word_valid <= 1'b0;
            busy          <= 1'b0;
            crc_err_cnt   <= 8'h00;
        end else begin
            crc_start <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_wr_en <= 1'b0;
            tx_start  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_message_done) begin
                        lat_func  <= func_code;
                        lat_addr  <= addr;
                        lat_data  <= data;
                        lat_crc   <= crc_rx_code;
                        crc_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_CRC_WAIT;
                    end
                end
                S_CRC_WAIT: begin
                    if (crc_done) begin
                        if (crc_calc != lat_crc) begin
                            crc_err_cnt <= sat_inc8(crc_err_cnt);
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            state <= S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if (dec_exc != 8'h00) begin
                        tx_start <= 1'b1;
                        tx_func  <= lat_func | 8'h80;
                        tx_exc   <= dec_exc;
                        tx_len   <= 8'd1;
                        state    <= S_WAIT_TX;
                    end else if (lat_func == 8'h03) begin
                        // Header and first read strobe leave together; words follow.
                        tx_start  <= 1'b1;
                        tx_func   <= 8'h03;
                        tx_exc    <= 8'h00;
                        tx_len    <= {lat_data[6:0], 1'b0};
                        reg_rd_en <= 1'b1;
                        reg_addr  <= lat_addr;
                        word_idx  <= 16'h0000;
                        state     <= S_RD_REQ;
                    end else begin
                        reg_wr_en <= 1'b1;
                        reg_addr  <= lat_addr;
                        reg_wdata <= lat_data;
                        state     <= S_WR;
                    end
                end
                S_RD_REQ: begin
                    state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    tx_word       <= reg_rdata;
                    tx_word_valid <= 1'b1;
                    state         <= S_RD_PUSH;
                end
                S_RD_PUSH: begin
                    if (tx_word_ready) begin
                        tx_word_valid <= 1'b0;
                        word_idx      <= idx_next;
                        if (idx_next == lat_data) begin
                            state <= S_WAIT_TX;
                        end else begin
                            reg_rd_en <= 1'b1;
                            reg_addr  <= lat_addr + idx_next;
                            state     <= S_RD_REQ;
                        end
                    end
                end
                S_WR: begin
                    tx_start <= 1'b1;
                    tx_func  <= 8'h06;
                    tx_exc   <= 8'h00;
                    tx_len   <= 8'd4;
                    state    <= S_WR_HDR;
                end
                S_WR_HDR: begin
                    tx_word       <= lat_addr;
                    tx_word_valid <= 1'b1;
                    word_idx      <= 16'h0000;
                    state         <= S_WR_PUSH;
                end
                S_WR_PUSH: begin
                    // Echo is two words: address first, then the written value.
                    if (tx_word_ready) begin
                        if (word_idx == 16'h0000) begin
                            tx_word  <= lat_data;
                            word_idx <= 16'h0001;
                        end else begin
                            tx_word_valid <= 1'b0;
                            state         <= S_WAIT_TX;
                        end
                    end
                end
                S_WAIT_TX: begin
                    if (tx_done) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modbus_req_ctrl.sv
// Scoreboard bench for modbus_req_ctrl: a register-file model answers reads, and expected
// headers, strobes and words are queued at request time and popped as the DUT produces them.
module tb_modbus_req_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rx_message_done = 1'b0;
    logic [7:0]  func_code = 8'h00;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data = 16'h0000;
    logic [15:0] crc_rx_code = 16'h0000;
    logic        crc_start;
    logic        crc_done = 1'b0;
    logic [15:0] crc_calc = 16'h0000;
    logic        reg_rd_en;
    logic        reg_wr_en;
    logic [15:0] reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = 16'h0000;
    logic        tx_start;
    logic [7:0]  tx_func;
    logic [7:0]  tx_exc;
    logic [7:0]  tx_len;
    logic [15:0] tx_word;
    logic        tx_word_valid;
    logic        tx_word_ready = 1'b1;
    logic        tx_done = 1'b0;
    logic        busy;
    logic [7:0]  crc_err_cnt;

    modbus_req_ctrl #(.REG_NUM(16'd16), .MAX_RD(16'd16)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .rx_message_done(rx_message_done), .func_code(func_code), .addr(addr),
        .data(data), .crc_rx_code(crc_rx_code),
        .crc_start(crc_start), .crc_done(crc_done), .crc_calc(crc_calc),
        .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .tx_start(tx_start), .tx_func(tx_func), .tx_exc(tx_exc), .tx_len(tx_len),
        .tx_word(tx_word), .tx_word_valid(tx_word_valid), .tx_word_ready(tx_word_ready),
        .tx_done(tx_done), .busy(busy), .crc_err_cnt(crc_err_cnt)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    int n_assert = 0;
    int n_fail = 0;
    int t_rx = 0;
    int t_crc = 0;
    int n_crc_start = 0;
    int exp_crc_starts = 0;
    logic [7:0] exp_err = 8'h00;
    logic bp = 1'b0;
    int bp_cnt = 0;

    logic [15:0] regs [16];
    logic [23:0] q_hdr [$];
    int          q_lat [$];
    logic [15:0] q_word [$];
    logic [15:0] q_rd [$];
    logic [31:0] q_wr [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Register file environment: read data one cycle after the strobe.
    always @(posedge clk_in) begin
        if (reg_rd_en) reg_rdata <= regs[reg_addr[3:0]];
        if (reg_wr_en) regs[reg_addr[3:0]] <= reg_wdata;
    end

    // Transmitter: always ready, or ready only after a word has waited 5 cycles.
    always @(posedge clk_in) begin
        #1;
        if (!bp) begin
            tx_word_ready = 1'b1;
        end else if (tx_word_ready) begin
            tx_word_ready = 1'b0;
            bp_cnt = 0;
        end else if (tx_word_valid) begin
            bp_cnt++;
            if (bp_cnt >= 5) tx_word_ready = 1'b1;
        end
    end

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_word = 16'h0000;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (crc_start) begin
                n_crc_start++;
                check_val("crc_start_lat", 32'(cyc - t_rx), 32'd1);
            end
            if (tx_start) begin
                if (q_hdr.size() == 0) check_val("hdr_unexpected", 32'(q_hdr.size()), 32'd1);
                else begin
                    check_val("hdr", {8'h00, tx_func, tx_exc, tx_len}, {8'h00, q_hdr.pop_front()});
                    check_val("hdr_lat", 32'(cyc - t_crc), 32'(q_lat.pop_front()));
                end
            end
            if (reg_rd_en) begin
                if (q_rd.size() == 0) check_val("rd_unexpected", 32'(q_rd.size()), 32'd1);
                else check_val("rd_addr", {16'h0, reg_addr}, {16'h0, q_rd.pop_front()});
            end
            if (reg_wr_en) begin
                if (q_wr.size() == 0) check_val("wr_unexpected", 32'(q_wr.size()), 32'd1);
                else check_val("wr", {reg_addr, reg_wdata}, q_wr.pop_front());
            end
            if (prev_valid && !prev_ready) begin
                check_val("valid_held", {31'h0, tx_word_valid}, 32'd1);
                check_val("word_stable", {16'h0, tx_word}, {16'h0, prev_word});
            end
            if (tx_word_valid && tx_word_ready) begin
                if (q_word.size() == 0) check_val("word_unexpected", 32'(q_word.size()), 32'd1);
                else check_val("word", {16'h0, tx_word}, {16'h0, q_word.pop_front()});
            end
            prev_valid = tx_word_valid;
            prev_ready = tx_word_ready;
            prev_word  = tx_word;
        end else begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end
    end

    task automatic push_exp(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d);
        logic [7:0] exc;
        exc = 8'h00;
        if (f == 8'h03) begin
            if (d == 16'd0 || d > 16'd16) exc = 8'h03;
            else if (({1'b0, a} + {1'b0, d}) > 17'd16) exc = 8'h02;
        end else if (f == 8'h06) begin
            if (a >= 16'd16) exc = 8'h02;
        end else begin
            exc = 8'h01;
        end
        if (exc != 8'h00) begin
            q_hdr.push_back({f | 8'h80, exc, 8'd1});
            q_lat.push_back(2);
        end else if (f == 8'h03) begin
            q_hdr.push_back({8'h03, 8'h00, d[6:0], 1'b0});
            q_lat.push_back(2);
            for (int i = 0; i < int'(d); i++) begin
                q_rd.push_back(16'(a + 16'(i)));
                q_word.push_back(regs[4'(a + 16'(i))]);
            end
        end else begin
            q_wr.push_back({a, d});
            q_hdr.push_back({8'h06, 8'h00, 8'd4});
            q_lat.push_back(3);
            q_word.push_back(a);
            q_word.push_back(d);
        end
    endtask

    task automatic drive_rx(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk_in); #1;
        func_code = f; addr = a; data = d; crc_rx_code = 16'h4321;
        rx_message_done = 1'b1;
        t_rx = cyc;
        exp_crc_starts++;
        @(posedge clk_in); #1;
        rx_message_done = 1'b0;
        func_code = 8'h00; addr = 16'h0; data = 16'h0; crc_rx_code = 16'h0;
    endtask

    task automatic drive_crc(input logic [15:0] calc);
        @(posedge clk_in); #1;
        crc_calc = calc; crc_done = 1'b1;
        t_crc = cyc;
        @(posedge clk_in); #1;
        crc_done = 1'b0; crc_calc = 16'h0;
    endtask

    task automatic finish_req();
        int n;
        n = 0;
        while ((q_hdr.size() + q_word.size() + q_rd.size() + q_wr.size()) != 0 && n < 2000) begin
            @(posedge clk_in);
            n++;
        end
        check_val("resp_pending", 32'(q_hdr.size() + q_word.size() + q_rd.size() + q_wr.size()), 32'd0);
        repeat (2) @(posedge clk_in);
        #1 tx_done = 1'b1;
        @(negedge clk_in) check_val("busy_before_done", {31'h0, busy}, 32'd1);
        @(posedge clk_in); #1 tx_done = 1'b0;
        @(negedge clk_in) check_val("busy_after_done", {31'h0, busy}, 32'd0);
    endtask

    task automatic do_req(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                          input logic bad);
        if (!bad) push_exp(f, a, d);
        drive_rx(f, a, d);
        drive_crc(bad ? 16'h1234 : 16'h4321);
        if (bad) begin
            exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
            repeat (2) @(posedge clk_in);
            @(negedge clk_in);
            check_val("busy_after_crc_err", {31'h0, busy}, 32'd0);
            check_val("crc_err_cnt", {24'h0, crc_err_cnt}, {24'h0, exp_err});
        end else begin
            finish_req();
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 100 && !tx_word_valid; i++) @(negedge clk_in);
        if (!tx_word_valid) check_val(tag, {31'h0, tx_word_valid}, 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic [7:0] err);
        check_val({tag, "_strobes"},
                  {26'h0, crc_start, reg_rd_en, reg_wr_en, tx_start, tx_word_valid, busy}, 32'd0);
        check_val({tag, "_reg"}, {reg_addr, reg_wdata}, 32'd0);
        check_val({tag, "_hdr"}, {8'h00, tx_func, tx_exc, tx_len}, 32'd0);
        check_val({tag, "_word"}, {16'h0, tx_word}, 32'd0);
        check_val({tag, "_errcnt"}, {24'h0, crc_err_cnt}, {24'h0, err});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'hA000 + 16'(i * 16'h0111);

        repeat (3) @(negedge clk_in);
        check_idle("reset", 8'h00);
        @(posedge clk_in); #1 rst_in = 1'b0;

        do_req(8'h03, 16'h0002, 16'd3, 1'b0);
        do_req(8'h06, 16'h0005, 16'hBEEF, 1'b0);
        check_val("regfile_written", {16'h0, regs[5]}, 32'h0000BEEF);
        do_req(8'h03, 16'h0005, 16'd1, 1'b0);
        do_req(8'h03, 16'h000E, 16'd2, 1'b0);

        do_req(8'h03, 16'h0002, 16'd3, 1'b1);
        for (int i = 0; i < 299; i++) do_req(8'h03, 16'h0000, 16'd1, 1'b1);

        do_req(8'h10, 16'h0000, 16'h0001, 1'b0);
        do_req(8'h03, 16'h000F, 16'd2, 1'b0);
        do_req(8'h03, 16'h0000, 16'd0, 1'b0);
        do_req(8'h03, 16'h0000, 16'd17, 1'b0);
        do_req(8'h06, 16'h0010, 16'h1234, 1'b0);

        // Backpressured read; a new frame plus stray crc_done/tx_done arrive mid-response.
        bp = 1'b1;
        fork
            do_req(8'h03, 16'h0001, 16'd4, 1'b0);
            begin
                wait_valid("inject_wait_timeout");
                @(posedge clk_in); #1;
                func_code = 8'h06; addr = 16'h0001; data = 16'h5555; crc_rx_code = 16'h4321;
                rx_message_done = 1'b1; crc_done = 1'b1; crc_calc = 16'h4321; tx_done = 1'b1;
                @(posedge clk_in); #1;
                rx_message_done = 1'b0; crc_done = 1'b0; crc_calc = 16'h0; tx_done = 1'b0;
                func_code = 8'h00; addr = 16'h0; data = 16'h0; crc_rx_code = 16'h0;
            end
        join
        check_val("ignored_frame_no_write", {16'h0, regs[1]}, {16'h0, 16'hA111});

        // Reset in the middle of a read response.
        push_exp(8'h03, 16'h0000, 16'd3);
        drive_rx(8'h03, 16'h0000, 16'd3);
        drive_crc(16'h4321);
        wait_valid("mid_read_wait_timeout");
        @(posedge clk_in); #1 rst_in = 1'b1;
        @(negedge clk_in);
        check_idle("rst_mid", 8'h00);
        q_hdr.delete(); q_lat.delete(); q_word.delete(); q_rd.delete(); q_wr.delete();
        exp_err = 8'h00;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        bp = 1'b0;
        repeat (4) @(negedge clk_in);
        check_idle("post_rst", 8'h00);

        do_req(8'h03, 16'h0007, 16'd2, 1'b0);
        check_val("crc_start_count", 32'(n_crc_start), 32'(exp_crc_starts));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
